// File: rtl/spraid_pkg.sv
// rtl/spraid_pkg.sv - shared types and constants for the spraid SPI target
package spraid_pkg;
   typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

   localparam int CMD_RW_BIT = 7;
   localparam int CMD_ADDR_W = 7;
   localparam int SPI_BITS   = 8;
   localparam int BIT_CNT_W  = $clog2(SPI_BITS);
endpackage

// File: rtl/spraid_spi_target_if.sv
// rtl/spraid_spi_target_if.sv - SPI link between controller (master) and target (slave)
interface spraid_spi_target_if;
   logic spi_clk_i;
   logic spi_cs_i;
   logic spi_mosi_i;
   logic spi_miso_o;
   logic spi_miso_oeb_o;

   modport master (
      output spi_clk_i, spi_cs_i, spi_mosi_i,
      input  spi_miso_o, spi_miso_oeb_o
   );

   modport slave (
      input  spi_clk_i, spi_cs_i, spi_mosi_i,
      output spi_miso_o, spi_miso_oeb_o
   );
endinterface

// File: rtl/spraid_sync.sv
// rtl/spraid_sync.sv - 2-flop synchronizer with selectable reset value
module spraid_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/spraid_spi_target.sv
// rtl/spraid_spi_target.sv - SPI mode-0 target with byte register file and local side port
module spraid_spi_target
   import spraid_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_n_i,
   spraid_spi_target_if.slave   spi,
   input  logic [AW-1:0]        loc_addr_i,
   output logic [7:0]           loc_data_o,
   output logic                 wr_pulse_o,
   output logic [AW-1:0]        wr_addr_o,
   output logic [7:0]           wr_data_o
);
   logic clk_s, cs_s, mosi_s, clk_d;
   logic rise, fall, byte_done, drive_miso, miso_q;
   state_t state, state_nxt;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [SPI_BITS-2:0]  rx_shift;
   logic [7:0]           rx_byte, tx_shift;
   logic [AW-1:0]        addr, addr_inc;
   logic [7:0]           mem [DEPTH];

   spraid_sync #(.RST_VAL(1'b0)) u_sync_clk  (.clk(wb_clk_i), .rst_n(wb_rst_n_i), .d(spi.spi_clk_i),  .q(clk_s));
   spraid_sync #(.RST_VAL(1'b1)) u_sync_cs   (.clk(wb_clk_i), .rst_n(wb_rst_n_i), .d(spi.spi_cs_i),   .q(cs_s));
   spraid_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(wb_clk_i), .rst_n(wb_rst_n_i), .d(spi.spi_mosi_i), .q(mosi_s));

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) clk_d <= 1'b0;
      else             clk_d <= clk_s;
   end

   assign rise      = clk_s & ~clk_d & ~cs_s;
   assign fall      = ~clk_s & clk_d & ~cs_s;
   assign rx_byte   = {rx_shift, mosi_s};
   assign byte_done = rise && (bit_cnt == BIT_CNT_W'(SPI_BITS - 1));
   assign addr_inc  = addr + 1'b1;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) state <= IDLE;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (cs_s) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = CMD;
            CMD:     if (byte_done) state_nxt = rx_byte[CMD_RW_BIT] ? READ : WRITE;
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      spi.spi_miso_oeb_o = (state == IDLE);
      drive_miso         = (state == READ);
   end

   // MISO is re-registered after the fall-driven shift so the pad sees one extra cycle of lag.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         bit_cnt        <= '0;
         rx_shift       <= '0;
         tx_shift       <= '0;
         addr           <= '0;
         miso_q         <= 1'b0;
         spi.spi_miso_o <= 1'b0;
         wr_pulse_o     <= 1'b0;
         wr_addr_o      <= '0;
         wr_data_o      <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         wr_pulse_o     <= 1'b0;
         spi.spi_miso_o <= drive_miso & miso_q;
         if (state != READ) miso_q <= 1'b0;

         if (state == IDLE) begin
            bit_cnt <= '0;
         end else if (rise) begin
            bit_cnt  <= bit_cnt + 1'b1;
            rx_shift <= rx_byte[SPI_BITS-2:0];
         end

         case (state)
            CMD: if (byte_done) begin
               addr     <= rx_byte[AW-1:0];
               tx_shift <= mem[rx_byte[AW-1:0]];
            end
            WRITE: if (byte_done) begin
               mem[addr]  <= rx_byte;
               wr_pulse_o <= 1'b1;
               wr_addr_o  <= addr;
               wr_data_o  <= rx_byte;
               addr       <= addr_inc;
            end
            READ: begin
               if (fall) begin
                  miso_q   <= tx_shift[7];
                  tx_shift <= {tx_shift[6:0], 1'b0};
               end
               if (byte_done) begin
                  addr     <= addr_inc;
                  tx_shift <= mem[addr_inc];
               end
            end
            default: ;
         endcase
      end
   end

   // Reads the pre-commit value when an SPI write hits the same address this cycle.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) loc_data_o <= '0;
      else             loc_data_o <= mem[loc_addr_i];
   end
endmodule

// File: tb/tb_spraid_spi_target.sv
// tb/tb_spraid_spi_target.sv - self-checking bench for spraid_spi_target
module tb_spraid_spi_target;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int HALF  = 8;

   typedef struct packed {
      logic [7:0] cmd, b0, b1, e0, e1;
   } vec_t;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [7:0]    d;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] loc_addr;
   logic [7:0]    loc_data;
   logic          wr_pulse;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;

   int   errors = 0;
   int   checks = 0;
   wr_t  wq[$];
   logic prev_pulse = 1'b0;
   vec_t vecs[6];

   always #5 clk = ~clk;

   spraid_spi_target_if spi();

   spraid_spi_target #(.DEPTH(DEPTH)) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .spi        (spi),
      .loc_addr_i (loc_addr),
      .loc_data_o (loc_data),
      .wr_pulse_o (wr_pulse),
      .wr_addr_o  (wr_addr),
      .wr_data_o  (wr_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (wr_pulse === 1'b1) begin
         if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wr_pulse: got addr %0d data 0x%0h expected no write", wr_addr, wr_data);
         end else begin
            e = wq.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e.a));
            check("wr_data", 32'(wr_data), 32'(e.d));
            check("wr_pulse_width", 32'(prev_pulse), 32'd0);
         end
      end
      prev_pulse = wr_pulse;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = '0;
      for (int i = 7; i > 7 - n; i--) begin
         spi.spi_mosi_i = tx[i];
         wait_clk(HALF);
         rx[i] = spi.spi_miso_o;
         spi.spi_clk_i = 1'b1;
         wait_clk(HALF);
         spi.spi_clk_i = 1'b0;
      end
   endtask

   task automatic cs_assert();
      spi.spi_cs_i = 1'b0;
      wait_clk(HALF);
      check("oeb_in_frame", 32'(spi.spi_miso_oeb_o), 32'd0);
   endtask

   task automatic cs_release();
      wait_clk(HALF);
      spi.spi_cs_i = 1'b1;
      wait_clk(HALF);
   endtask

   task automatic loc_check(input logic [AW-1:0] a, input logic [7:0] exp, input string name);
      loc_addr = a;
      @(negedge clk);
      check(name, 32'(loc_data), 32'(exp));
   endtask

   task automatic run_frame(input vec_t v, input string name);
      logic [7:0]    rx;
      logic [AW-1:0] a, a1;
      a  = v.cmd[AW-1:0];
      a1 = a + 1'b1;
      cs_assert();
      spi_bits(v.cmd, 8, rx);
      check({name, "_cmd_miso"}, 32'(spi.spi_miso_o), 32'd0);
      if (!v.cmd[7]) begin
         wq.push_back({a, v.e0});
         wq.push_back({a1, v.e1});
      end
      spi_bits(v.b0, 8, rx);
      if (v.cmd[7]) check({name, "_rd0"}, 32'(rx), 32'(v.e0));
      spi_bits(v.b1, 8, rx);
      if (v.cmd[7]) check({name, "_rd1"}, 32'(rx), 32'(v.e1));
      cs_release();
      check({name, "_drain"}, 32'(wq.size()), 32'd0);
      if (!v.cmd[7]) begin
         loc_check(a, v.e0, {name, "_loc0"});
         loc_check(a1, v.e1, {name, "_loc1"});
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rx, rx2;
      spi.spi_clk_i  = 1'b0;
      spi.spi_cs_i   = 1'b1;
      spi.spi_mosi_i = 1'b0;
      loc_addr       = '0;

      vecs[0] = '{8'h03, 8'hA5, 8'h5A, 8'hA5, 8'h5A};
      vecs[1] = '{8'h83, 8'h00, 8'h3C, 8'hA5, 8'h5A};
      vecs[2] = '{8'h0F, 8'h11, 8'h22, 8'h11, 8'h22};
      vecs[3] = '{8'h8F, 8'hFF, 8'h00, 8'h11, 8'h22};
      vecs[4] = '{8'h15, 8'h77, 8'h88, 8'h77, 8'h88};
      vecs[5] = '{8'h95, 8'hFF, 8'hFF, 8'h77, 8'h88};

      wait_clk(3);
      check("rst_miso", 32'(spi.spi_miso_o), 32'd0);
      check("rst_oeb", 32'(spi.spi_miso_oeb_o), 32'd1);
      rst_n = 1'b1;
      wait_clk(2);
      check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_loc_data", 32'(loc_data), 32'd0);

      for (int v = 0; v < 6; v++) run_frame(vecs[v], $sformatf("vec%0d", v));

      // abort: partial byte into addr 3 must leave 0xA5 intact
      cs_assert();
      spi_bits(8'h03, 8, rx);
      spi_bits(8'hFF, 5, rx);
      cs_release();
      loc_check(4'd3, 8'hA5, "abort_mem");
      run_frame('{8'h08, 8'h3C, 8'hC7, 8'h3C, 8'hC7}, "post_abort");

      // reset in the middle of a write byte
      cs_assert();
      spi_bits(8'h02, 8, rx);
      spi_bits(8'hFF, 4, rx);
      rst_n = 1'b0;
      wait_clk(2);
      check("midrst_miso", 32'(spi.spi_miso_o), 32'd0);
      check("midrst_oeb", 32'(spi.spi_miso_oeb_o), 32'd1);
      check("midrst_wr_pulse", 32'(wr_pulse), 32'd0);
      check("midrst_wr_addr", 32'(wr_addr), 32'd0);
      check("midrst_wr_data", 32'(wr_data), 32'd0);
      check("midrst_loc_data", 32'(loc_data), 32'd0);
      spi.spi_cs_i  = 1'b1;
      spi.spi_clk_i = 1'b0;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(4);
      for (int i = 0; i < DEPTH; i++) loc_check(AW'(i), 8'h00, $sformatf("midrst_mem%0d", i));
      run_frame('{8'h01, 8'h99, 8'h66, 8'h99, 8'h66}, "post_rst");

      // collision: commit to addr 2 while the local port reads addr 2
      run_frame('{8'h02, 8'h44, 8'h45, 8'h44, 8'h45}, "pre_coll");
      loc_addr = 4'd2;
      cs_assert();
      spi_bits(8'h02, 8, rx);
      wq.push_back({4'd2, 8'hC3});
      fork
         spi_bits(8'hC3, 8, rx2);
         begin : watch
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 300 && !seen; k++) begin
               @(negedge clk);
               if (wr_pulse === 1'b1) begin
                  seen = 1'b1;
                  check("collision_old", 32'(loc_data), 32'h44);
               end
            end
            if (!seen) begin
               checks++;
               errors++;
               $display("FAIL collision_timeout: got no wr_pulse expected one within 300 cycles");
            end else begin
               @(negedge clk);
               check("collision_new", 32'(loc_data), 32'hC3);
            end
         end
      join
      cs_release();
      check("collision_drain", 32'(wq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
